// File: rtl/vram_port_arbiter_if.sv
// vram_port_arbiter_if: groups the display read port (D), the AXI register-side
// port (B) and the single text-VRAM BRAM port of the arbiter.
//
// Handshake: a requester raises *_req together with its payload and holds both
// stable until the cycle in which *_gnt is high; that cycle is the transfer.
// *_gnt is only ever high while the matching *_req is high, and at most one gnt
// is high per cycle. Read data returns later as a single-cycle *_rvalid pulse
// with *_rdata; writes never produce *_rvalid.
interface vram_port_arbiter_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
);
  // display port
  logic              d_req;
  logic [ADDR_W-1:0] d_addr;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  // bus port
  logic                b_req;
  logic [DATA_W/8-1:0] b_we;
  logic [ADDR_W-1:0]   b_addr;
  logic [DATA_W-1:0]   b_wdata;
  logic                b_gnt;
  logic                b_rvalid;
  logic [DATA_W-1:0]   b_rdata;
  // BRAM port
  logic                mem_en;
  logic [DATA_W/8-1:0] mem_wea;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_rdata;

  // arbiter side
  modport slave (
    input  d_req, d_addr, b_req, b_we, b_addr, b_wdata, mem_rdata,
    output d_gnt, d_rvalid, d_rdata, b_gnt, b_rvalid, b_rdata,
    output mem_en, mem_wea, mem_addr, mem_wdata
  );

  // requesters and BRAM side
  modport master (
    output d_req, d_addr, b_req, b_we, b_addr, b_wdata, mem_rdata,
    input  d_gnt, d_rvalid, d_rdata, b_gnt, b_rvalid, b_rdata,
    input  mem_en, mem_wea, mem_addr, mem_wdata
  );
endinterface

// File: rtl/vram_port_arbiter.sv
// vram_port_arbiter: shares the single text-VRAM BRAM port between the display
// fetch pipeline (port D, read-only) and the AXI register side (port B).
// Grants are combinational, the winning command is registered onto mem_* one
// cycle later, and every read carries an owner tag down a shift register so the
// BRAM data can be steered back to the right port.
//
// Build option: define VRAM_ARB_RR_EN to replace fixed display priority (with a
// bus starvation guard) by two-way round-robin arbitration.
module vram_port_arbiter #(
  parameter int ADDR_W       = 11,
  parameter int DATA_W       = 32,
  parameter int RD_LAT       = 2,
  parameter int MAX_BUS_WAIT = 4
) (
  input  logic                 S_AXI_ACLK,
  input  logic                 S_AXI_ARESET,
  vram_port_arbiter_if.slave   bus
);

  localparam int BE_W  = DATA_W / 8;
  localparam int TAG_D = RD_LAT + 1;

  logic d_win;
  logic b_win;
  logic d_grant;
  logic b_grant;

  // No grant may leave the arbiter while reset is held.
  assign d_grant   = d_win & ~S_AXI_ARESET;
  assign b_grant   = b_win & ~S_AXI_ARESET;
  assign bus.d_gnt = d_grant;
  assign bus.b_gnt = b_grant;

`ifdef VRAM_ARB_RR_EN
  // 1 = bus port owned the most recent grant, 0 = display port.
  logic last_owner;

  // Round-robin pick: on contention the port that did not win last time wins.
  always_comb begin
    d_win = 1'b0;
    b_win = 1'b0;
    if (bus.d_req && bus.b_req) begin
      d_win = last_owner;
      b_win = ~last_owner;
    end else begin
      d_win = bus.d_req;
      b_win = bus.b_req;
    end
  end

  // Remember who won so the other port gets the next contended cycle.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      last_owner <= 1'b1;
    end else if (d_grant) begin
      last_owner <= 1'b0;
    end else if (b_grant) begin
      last_owner <= 1'b1;
    end
  end
`else
  localparam logic [7:0] MAX_WAIT = 8'(MAX_BUS_WAIT);

  logic [7:0] starve_cnt;
  logic       starve_sat;

  assign starve_sat = (starve_cnt >= MAX_WAIT);

  // Display has priority unless the bus has already lost MAX_BUS_WAIT cycles.
  always_comb begin
    d_win = bus.d_req & ~starve_sat;
    b_win = bus.b_req & ~d_win;
  end

  // Count consecutive cycles the bus waited; saturate at the forcing threshold.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      starve_cnt <= '0;
    end else if (!bus.b_req || b_grant) begin
      starve_cnt <= '0;
    end else if (!starve_sat) begin
      starve_cnt <= starve_cnt + 8'd1;
    end
  end
`endif

  // Register the winning command onto the BRAM port.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      bus.mem_en    <= 1'b0;
      bus.mem_wea   <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      bus.mem_en  <= d_grant | b_grant;
      bus.mem_wea <= b_grant ? bus.b_we : {BE_W{1'b0}};
      if (b_grant) begin
        bus.mem_addr  <= bus.b_addr;
        bus.mem_wdata <= bus.b_wdata;
      end else if (d_grant) begin
        bus.mem_addr  <= bus.d_addr;
      end
    end
  end

  // Read tags: tag_v marks a read in flight, tag_b says it belongs to the bus.
  // Slot 0 lines up with mem_en, slot RD_LAT with valid mem_rdata.
  logic [TAG_D-1:0] tag_v;
  logic [TAG_D-1:0] tag_b;
  logic             new_v;

  assign new_v = d_grant | (b_grant & ~(|bus.b_we));

  // Shift the tag pipe every cycle; bus writes enter as empty slots.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      tag_v <= '0;
      tag_b <= '0;
    end else begin
      tag_v <= {tag_v[TAG_D-2:0], new_v};
      tag_b <= {tag_b[TAG_D-2:0], b_grant};
    end
  end

  logic ret_d;
  logic ret_b;

  assign ret_d = tag_v[RD_LAT] & ~tag_b[RD_LAT];
  assign ret_b = tag_v[RD_LAT] &  tag_b[RD_LAT];

  // Capture returning BRAM data for its owner; rdata holds between pulses.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      bus.d_rvalid <= 1'b0;
      bus.b_rvalid <= 1'b0;
      bus.d_rdata  <= '0;
      bus.b_rdata  <= '0;
    end else begin
      bus.d_rvalid <= ret_d;
      bus.b_rvalid <= ret_b;
      if (ret_d) begin
        bus.d_rdata <= bus.mem_rdata;
      end
      if (ret_b) begin
        bus.b_rdata <= bus.mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_vram_port_arbiter.sv
// tb_vram_port_arbiter: directed tests for vram_port_arbiter with a BRAM model,
// a cycle-level reference model of the arbitration rules and a queue of
// expected read returns, plus literal checks on the headline scenarios.
module tb_vram_port_arbiter;

  localparam int ADDR_W       = 11;
  localparam int DATA_W       = 32;
  localparam int RD_LAT       = 2;
  localparam int MAX_BUS_WAIT = 4;

  logic clk;
  logic rst;

  int check_cnt = 0;
  int fail_cnt  = 0;
  int cyc       = 0;

  vram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  vram_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .MAX_BUS_WAIT(MAX_BUS_WAIT)
  ) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESET (rst),
    .bus          (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- BRAM model ----------------
  logic [31:0] ram    [0:2047];
  logic [31:0] shadow [0:2047];
  logic [31:0] rd_pipe [0:RD_LAT-1];

  initial begin
    for (int i = 0; i < 2048; i++) begin
      ram[i]    = 32'hCAFE0000 | 32'(i);
      shadow[i] = 32'hCAFE0000 | 32'(i);
    end
    for (int i = 0; i < RD_LAT; i++) rd_pipe[i] = '0;
  end

  always @(posedge clk) begin
    if (bus.mem_en) begin
      for (int j = 0; j < 4; j++)
        if (bus.mem_wea[j]) ram[bus.mem_addr][8*j +: 8] <= bus.mem_wdata[8*j +: 8];
      rd_pipe[0] <= ram[bus.mem_addr];
    end
    for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end

  assign bus.mem_rdata = rd_pipe[RD_LAT-1];

  // ---------------- checking helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  int          pend_cyc[$];
  bit          pend_b[$];
  logic [31:0] exp_q[$];

  logic        exp_en;
  logic [3:0]  exp_wea;
  logic [10:0] exp_addr;
  logic [31:0] exp_wdata;
  logic [31:0] exp_d_rdata;
  logic [31:0] exp_b_rdata;
  int          m_starve;
  bit          m_last_b;

  // logs for the literal checks
  int          gnt_cyc[$];
  bit          gnt_who[$];
  int          mem_cyc[$];
  logic [10:0] mem_addr_log[$];
  logic [3:0]  mem_wea_log[$];
  int          rvd_cyc[$];
  logic [31:0] rvd_dat[$];
  int          rvb_cyc[$];
  logic [31:0] rvb_dat[$];

  task automatic clear_logs();
    gnt_cyc.delete(); gnt_who.delete();
    mem_cyc.delete(); mem_addr_log.delete(); mem_wea_log.delete();
    rvd_cyc.delete(); rvd_dat.delete(); rvb_cyc.delete(); rvb_dat.delete();
  endtask

  always @(negedge clk) begin
    bit          exp_dv, exp_bv, want_d, want_b;
    cyc++;
    if (rst) begin
      pend_cyc.delete(); pend_b.delete(); exp_q.delete();
      exp_en = 1'b0; exp_wea = '0; exp_addr = '0; exp_wdata = '0;
      exp_d_rdata = '0; exp_b_rdata = '0;
      m_starve = 0; m_last_b = 1'b1;
      chk("rst_d_gnt",     {31'b0, bus.d_gnt},    32'd0);
      chk("rst_b_gnt",     {31'b0, bus.b_gnt},    32'd0);
      chk("rst_mem_en",    {31'b0, bus.mem_en},   32'd0);
      chk("rst_mem_wea",   {28'b0, bus.mem_wea},  32'd0);
      chk("rst_mem_addr",  {21'b0, bus.mem_addr}, 32'd0);
      chk("rst_mem_wdata", bus.mem_wdata,         32'd0);
      chk("rst_d_rvalid",  {31'b0, bus.d_rvalid}, 32'd0);
      chk("rst_b_rvalid",  {31'b0, bus.b_rvalid}, 32'd0);
      chk("rst_d_rdata",   bus.d_rdata,           32'd0);
      chk("rst_b_rdata",   bus.b_rdata,           32'd0);
    end else begin
      // BRAM command issued for the grant of the previous cycle
      chk("mem_en", {31'b0, bus.mem_en}, {31'b0, exp_en});
      chk("mem_wea", {28'b0, bus.mem_wea}, exp_en ? {28'b0, exp_wea} : 32'd0);
      if (exp_en) begin
        chk("mem_addr", {21'b0, bus.mem_addr}, {21'b0, exp_addr});
        if (exp_wea != 0) chk("mem_wdata", bus.mem_wdata, exp_wdata);
      end
      if (bus.mem_en) begin
        mem_cyc.push_back(cyc); mem_addr_log.push_back(bus.mem_addr);
        mem_wea_log.push_back(bus.mem_wea);
      end

      // read returns due this cycle
      exp_dv = 1'b0; exp_bv = 1'b0;
      if (pend_cyc.size() > 0 && pend_cyc[0] <= cyc) begin
        if (pend_b[0]) begin exp_bv = 1'b1; exp_b_rdata = exp_q[0]; end
        else           begin exp_dv = 1'b1; exp_d_rdata = exp_q[0]; end
        void'(pend_cyc.pop_front()); void'(pend_b.pop_front()); void'(exp_q.pop_front());
      end
      chk("d_rvalid", {31'b0, bus.d_rvalid}, {31'b0, exp_dv});
      chk("b_rvalid", {31'b0, bus.b_rvalid}, {31'b0, exp_bv});
      chk("d_rdata", bus.d_rdata, exp_d_rdata);
      chk("b_rdata", bus.b_rdata, exp_b_rdata);
      if (bus.d_rvalid) begin rvd_cyc.push_back(cyc); rvd_dat.push_back(bus.d_rdata); end
      if (bus.b_rvalid) begin rvb_cyc.push_back(cyc); rvb_dat.push_back(bus.b_rdata); end

      // who must win this cycle
      want_d = 1'b0; want_b = 1'b0;
`ifdef VRAM_ARB_RR_EN
      if (bus.d_req && bus.b_req) begin
        if (m_last_b) want_d = 1'b1; else want_b = 1'b1;
      end else begin
        want_d = bus.d_req; want_b = bus.b_req;
      end
`else
      if (bus.d_req && m_starve < MAX_BUS_WAIT) want_d = 1'b1;
      else if (bus.b_req)                       want_b = 1'b1;
`endif
      chk("d_gnt", {31'b0, bus.d_gnt}, {31'b0, want_d});
      chk("b_gnt", {31'b0, bus.b_gnt}, {31'b0, want_b});
      if (bus.d_gnt || bus.b_gnt) begin
        gnt_cyc.push_back(cyc); gnt_who.push_back(bus.b_gnt);
      end

      // consequences of the model's grant
      exp_en = want_d | want_b;
      exp_wea = '0;
      if (want_d) begin
        exp_addr = bus.d_addr;
        pend_cyc.push_back(cyc + 2 + RD_LAT); pend_b.push_back(1'b0);
        exp_q.push_back(shadow[bus.d_addr]);
        m_last_b = 1'b0;
      end else if (want_b) begin
        exp_addr = bus.b_addr; exp_wea = bus.b_we; exp_wdata = bus.b_wdata;
        if (bus.b_we == 0) begin
          pend_cyc.push_back(cyc + 2 + RD_LAT); pend_b.push_back(1'b1);
          exp_q.push_back(shadow[bus.b_addr]);
        end else begin
          for (int j = 0; j < 4; j++)
            if (bus.b_we[j]) shadow[bus.b_addr][8*j +: 8] = bus.b_wdata[8*j +: 8];
        end
        m_last_b = 1'b1;
      end
      if (!bus.b_req || want_b)         m_starve = 0;
      else if (m_starve < MAX_BUS_WAIT) m_starve = m_starve + 1;
    end
  end

  // ---------------- driver tasks (entered just after a rising edge) ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic d_read(input logic [10:0] a);
    bit ok = 1'b0;
    bus.d_req = 1'b1; bus.d_addr = a;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (bus.d_gnt) ok = 1'b1;
    end
    check_cnt++;
    if (!ok) begin fail_cnt++; $display("FAIL d_gnt_timeout: no grant for addr %h", a); end
    @(posedge clk); #1;
    bus.d_req = 1'b0;
  endtask

  task automatic b_op(input logic [3:0] we, input logic [10:0] a, input logic [31:0] wd);
    bit ok = 1'b0;
    bus.b_req = 1'b1; bus.b_we = we; bus.b_addr = a; bus.b_wdata = wd;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (bus.b_gnt) ok = 1'b1;
    end
    check_cnt++;
    if (!ok) begin fail_cnt++; $display("FAIL b_gnt_timeout: no grant for addr %h", a); end
    @(posedge clk); #1;
    bus.b_req = 1'b0; bus.b_we = '0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    wait_cyc(n);
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    string pat;
    logic [10:0] d_tab [0:11];
    rst = 1'b1;
    bus.d_req = 1'b0; bus.d_addr = '0;
    bus.b_req = 1'b0; bus.b_we = '0; bus.b_addr = '0; bus.b_wdata = '0;
    @(posedge clk); #1;
    do_reset(3);
    wait_cyc(2);

    // 1: single display read
    clear_logs();
    d_read(11'h005);
    wait_cyc(8);
    chk("t1_gnt_count", gnt_cyc.size(), 1);
    chk("t1_rvd_count", rvd_cyc.size(), 1);
    chk("t1_rvb_count", rvb_cyc.size(), 0);
    if (gnt_cyc.size() == 1 && mem_cyc.size() == 1 && rvd_cyc.size() == 1) begin
      chk("t1_mem_lat",  mem_cyc[0] - gnt_cyc[0], 1);
      chk("t1_mem_addr", {21'b0, mem_addr_log[0]}, 32'h005);
      chk("t1_rd_lat",   rvd_cyc[0] - gnt_cyc[0], 4);
      chk("t1_rd_data",  rvd_dat[0], 32'hCAFE0005);
    end

    // 2: bus byte write, then read it back
    clear_logs();
    b_op(4'b0101, 11'h7FF, 32'h11223344);
    wait_cyc(8);
    chk("t2_gnt_count", gnt_cyc.size(), 1);
    chk("t2_rvb_count", rvb_cyc.size(), 0);
    if (gnt_cyc.size() == 1 && mem_cyc.size() == 1) begin
      chk("t2_mem_lat",  mem_cyc[0] - gnt_cyc[0], 1);
      chk("t2_mem_wea",  {28'b0, mem_wea_log[0]}, 32'h5);
      chk("t2_mem_addr", {21'b0, mem_addr_log[0]}, 32'h7FF);
    end
    clear_logs();
    b_op(4'b0000, 11'h7FF, 32'h0);
    wait_cyc(8);
    chk("t2_rb_count", rvb_cyc.size(), 1);
    if (rvb_cyc.size() == 1) chk("t2_rb_data", rvb_dat[0], 32'hCA220744);

    // 3/4: contention from reset, both held for 10 cycles
    do_reset(2);
    wait_cyc(1);
    clear_logs();
    bus.d_req = 1'b1; bus.d_addr = 11'h030;
    bus.b_req = 1'b1; bus.b_we = '0; bus.b_addr = 11'h040;
    wait_cyc(10);
    bus.d_req = 1'b0; bus.b_req = 1'b0;
    wait_cyc(8);
`ifdef VRAM_ARB_RR_EN
    pat = "DBDBDBDBDB";
`else
    pat = "DDDDBDDDDB";
`endif
    chk("t3_gnt_count", gnt_cyc.size(), 10);
    for (int i = 0; i < 10 && i < gnt_cyc.size(); i++)
      chk($sformatf("t3_owner_%0d", i), {31'b0, gnt_who[i]}, (pat[i] == "B") ? 32'd1 : 32'd0);
`ifdef VRAM_ARB_RR_EN
    chk("t3_rvd_count", rvd_cyc.size(), 5);
    chk("t3_rvb_count", rvb_cyc.size(), 5);
`else
    chk("t3_rvd_count", rvd_cyc.size(), 8);
    chk("t3_rvb_count", rvb_cyc.size(), 2);
`endif
    if (rvb_cyc.size() > 0) chk("t3_b_data", rvb_dat[0], 32'hCAFE0040);
    if (rvd_cyc.size() > 0) chk("t3_d_data", rvd_dat[0], 32'hCAFE0030);

    // 5: pipelined display reads 0x000..0x007
    clear_logs();
    for (int i = 0; i < 8; i++) begin
      bus.d_req = 1'b1; bus.d_addr = 11'(i);
      wait_cyc(1);
    end
    bus.d_req = 1'b0;
    wait_cyc(8);
    chk("t5_rvd_count", rvd_cyc.size(), 8);
    for (int i = 0; i < 8 && i < rvd_cyc.size(); i++) begin
      chk($sformatf("t5_cyc_%0d", i), rvd_cyc[i] - rvd_cyc[0], i);
      chk($sformatf("t5_dat_%0d", i), rvd_dat[i], 32'hCAFE0000 + 32'(i));
    end

    // 6: reset one cycle after a display grant
    clear_logs();
    d_read(11'h020);
    do_reset(3);
    wait_cyc(8);
    chk("t6_no_rvalid", rvd_cyc.size(), 0);
    d_read(11'h021);
    wait_cyc(8);
    chk("t6_after_count", rvd_cyc.size(), 1);
    if (rvd_cyc.size() == 1) chk("t6_after_data", rvd_dat[0], 32'hCAFE0021);

    // mixed traffic: continuous display stream against bus writes and reads
    for (int i = 0; i < 12; i++) d_tab[i] = 11'h010 + 11'(i % 6);
    fork
      begin
        for (int i = 0; i < 12; i++) d_read(d_tab[i]);
      end
      begin
        b_op(4'b1111, 11'h010, 32'hA5A50001);
        b_op(4'b0000, 11'h010, 32'h0);
        b_op(4'b1000, 11'h012, 32'h77000000);
        b_op(4'b0000, 11'h012, 32'h0);
        b_op(4'b0011, 11'h015, 32'h0000BEEF);
        b_op(4'b0000, 11'h7FF, 32'h0);
      end
    join
    wait_cyc(10);
    chk("mix_drain", pend_cyc.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", check_cnt, fail_cnt);
    $finish;
  end

endmodule
